conv_window_feeder: RTL and testbench

//  Producer side of the convUnit window interface. Buffers one fp16 multi-channel image tile

---
 rtl/conv_window_feeder.sv | 149 ++++++++++++++
 tb/tb_conv_window_feeder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_feeder.sv
// Buffers one multi-channel tile streamed in raster order and presents every
// stride-1, no-padding KxK window to convUnit, pacing on cu_out_valid.
module conv_window_feeder #(
  parameter int data_width    = 16,
  parameter int input_channel = 2,
  parameter int image_length  = 4,
  parameter int image_width   = 4,
  parameter int weight_length = 3,
  parameter int weight_width  = 3
) (
  input  logic                                                           clk,
  input  logic                                                           reset,
  input  logic                                                           start,
  input  logic [input_channel*data_width-1:0]                            in_data,
  input  logic                                                           in_valid,
  output logic                                                           in_ready,
  output logic [0:input_channel*weight_length*weight_width*data_width-1] image,
  output logic                                                           conv_en,
  input  logic                                                           cu_out_valid,
  output logic [((image_length > 1) ? $clog2(image_length) : 1)-1:0]     win_row,
  output logic [((image_width > 1) ? $clog2(image_width) : 1)-1:0]       win_col,
  output logic                                                           busy,
  output logic                                                           frame_done
);

  localparam int C        = input_channel;
  localparam int H        = image_length;
  localparam int W        = image_width;
  localparam int KL       = weight_length;
  localparam int KW       = weight_width;
  localparam int NPIX     = H * W;
  localparam int AW       = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int RW       = (H > 1) ? $clog2(H) : 1;
  localparam int CW       = (W > 1) ? $clog2(W) : 1;
  localparam int IMG_BITS = C * KL * KW * data_width;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    BUILD = 3'd2,
    ISSUE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                    state, state_next;
  logic [AW-1:0]             count, count_next;
  logic [RW-1:0]             row_next;
  logic [CW-1:0]             col_next;
  logic                      wr_en;
  logic [C*data_width-1:0]   buf_mem [NPIX];
  logic [0:IMG_BITS-1]       window;
  logic [AW-1:0]             pix_addr;
  logic                      last_window;

  assign last_window = (win_row == RW'(H - KL)) && (win_col == CW'(W - KW));

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    count_next = count;
    row_next   = win_row;
    col_next   = win_col;
    wr_en      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          count_next = '0;
          row_next   = '0;
          col_next   = '0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          wr_en      = 1'b1;
          count_next = count + 1'b1;
          if (count == AW'(NPIX - 1)) state_next = BUILD;
        end
      end
      BUILD: state_next = ISSUE;
      ISSUE: begin
        // A held-high cu_out_valid is consumed once here; BUILD always follows.
        if (cu_out_valid) begin
          if (last_window) begin
            state_next = DONE;
          end else begin
            state_next = BUILD;
            if (win_col == CW'(W - KW)) begin
              col_next = '0;
              row_next = win_row + 1'b1;
            end else begin
              col_next = win_col + 1'b1;
            end
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Gather window element (c,r,k) into slot c*KL*KW + r*KW + k, slot 0 at the MSBs.
  always_comb begin
    window   = '0;
    pix_addr = '0;
    for (int c = 0; c < C; c++) begin
      for (int r = 0; r < KL; r++) begin
        for (int k = 0; k < KW; k++) begin
          pix_addr = AW'((int'(win_row) + r) * W + int'(win_col) + k);
          window[(c*KL*KW + r*KW + k)*data_width +: data_width] =
            buf_mem[pix_addr][c*data_width +: data_width];
        end
      end
    end
  end

  // NOTE: the tile buffer is deliberately left out of reset; every entry is
  // rewritten during LOAD before BUILD can read it.
  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[count] <= in_data;
  end

  // Outputs are flops fed from the next state so they change cleanly on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      win_row    <= '0;
      win_col    <= '0;
      image      <= '0;
      conv_en    <= 1'b0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      win_row    <= row_next;
      win_col    <= col_next;
      conv_en    <= (state_next == ISSUE);
      in_ready   <= (state_next == LOAD);
      busy       <= (state_next != IDLE);
      frame_done <= (state_next == DONE);
      if (state == BUILD) image <= window;
    end
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder with the default 2ch 4x4 tile, 3x3 window;
// expected windows come from the pixel formula ch0 = off+n, ch1 = 0x100+off+n.
module tb_conv_window_feeder;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [0:287] image;
  logic         conv_en;
  logic         cu_out_valid;
  logic [1:0]   win_row;
  logic [1:0]   win_col;
  logic         busy;
  logic         frame_done;

  int tests = 0;
  int fails = 0;

  conv_window_feeder dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .image        (image),
    .conv_en      (conv_en),
    .cu_out_valid (cu_out_valid),
    .win_row      (win_row),
    .win_col      (win_col),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_pos(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_img(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [287:0] exp_win(input int r, input int c, input logic [15:0] off);
    logic [287:0] v;
    logic [15:0]  e;
    int           n;
    int           idx;
    v = '0;
    for (int ch = 0; ch < 2; ch++)
      for (int i = 0; i < 3; i++)
        for (int k = 0; k < 3; k++) begin
          n   = (r + i) * 4 + c + k;
          e   = 16'(n) + off + ((ch == 1) ? 16'h0100 : 16'h0000);
          idx = ch * 9 + i * 3 + k;
          v[287 - idx*16 -: 16] = e;
        end
    return v;
  endfunction

  // Start a frame and stream 16 pixels; optional idle cycle after each pixel.
  task automatic load_tile(input logic [15:0] off, input bit gap);
    logic [15:0] ch0;
    logic [15:0] ch1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_bit("load_in_ready", in_ready, 1'b1);
    check_bit("load_busy", busy, 1'b1);
    for (int n = 0; n < 16; n++) begin
      ch0      = 16'(n) + off;
      ch1      = 16'h0100 + 16'(n) + off;
      in_data  = {ch1, ch0};
      in_valid = 1'b1;
      tick();
      if (gap && n != 15) begin
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        tick();
      end
    end
    in_valid = 1'b0;
    check_bit("in_ready_after_last", in_ready, 1'b0);
    check_bit("conv_en_in_build", conv_en, 1'b0);
    tick();
    check_bit("first_conv_en", conv_en, 1'b1);
  endtask

  // Consume all four windows, replying 5 cycles after each conv_en rise.
  task automatic run_frame(input logic [15:0] off);
    for (int w = 0; w < 4; w++) begin
      check_bit("win_conv_en", conv_en, 1'b1);
      check_pos("win_row", win_row, 2'(w / 2));
      check_pos("win_col", win_col, 2'(w % 2));
      check_img("win_image", image, exp_win(w / 2, w % 2, off));
      for (int i = 0; i < 4; i++) tick();
      check_img("win_image_held", image, exp_win(w / 2, w % 2, off));
      check_bit("win_conv_en_held", conv_en, 1'b1);
      cu_out_valid = 1'b1;
      tick();
      cu_out_valid = 1'b0;
      check_bit("gap_conv_en", conv_en, 1'b0);
      if (w < 3) begin
        check_bit("no_early_done", frame_done, 1'b0);
        tick();
      end
    end
    check_bit("frame_done_pulse", frame_done, 1'b1);
    check_bit("busy_in_done", busy, 1'b1);
    tick();
    check_bit("frame_done_cleared", frame_done, 1'b0);
    check_bit("busy_after_done", busy, 1'b0);
    check_img("image_keeps_last", image, exp_win(1, 1, off));
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    in_data      = '0;
    in_valid     = 1'b0;
    cu_out_valid = 1'b0;

    // Reset state and ignored strobes in IDLE.
    tick();
    tick();
    reset = 1'b0;
    check_img("rst_image", image, '0);
    check_bit("rst_conv_en", conv_en, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_pos("rst_win_row", win_row, 2'd0);
    check_pos("rst_win_col", win_col, 2'd0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_frame_done", frame_done, 1'b0);
    in_valid     = 1'b1;
    cu_out_valid = 1'b1;
    tick();
    in_valid     = 1'b0;
    cu_out_valid = 1'b0;
    tick();
    check_bit("idle_ignore_busy", busy, 1'b0);
    check_bit("idle_ignore_in_ready", in_ready, 1'b0);
    check_bit("idle_ignore_conv_en", conv_en, 1'b0);

    // Back-to-back pixel stream, delayed replies.
    load_tile(16'h0000, 1'b0);
    run_frame(16'h0000);

    // Gapped pixel stream gives identical windows.
    tick();
    load_tile(16'h0000, 1'b1);
    run_frame(16'h0000);

    // cu_out_valid held high: windows back-to-back with one BUILD gap each.
    tick();
    cu_out_valid = 1'b1;
    load_tile(16'h0000, 1'b0);
    for (int w = 0; w < 4; w++) begin
      check_bit("tied_conv_en", conv_en, 1'b1);
      check_pos("tied_win_row", win_row, 2'(w / 2));
      check_pos("tied_win_col", win_col, 2'(w % 2));
      check_img("tied_image", image, exp_win(w / 2, w % 2, 16'h0000));
      tick();
      check_bit("tied_gap", conv_en, 1'b0);
      if (w < 3) tick();
    end
    check_bit("tied_frame_done", frame_done, 1'b1);
    cu_out_valid = 1'b0;
    tick();
    check_bit("tied_busy_after", busy, 1'b0);

    // Reset in ISSUE at window (0,1), then a fresh frame with new data.
    load_tile(16'h0000, 1'b0);
    cu_out_valid = 1'b1;
    tick();
    cu_out_valid = 1'b0;
    tick();
    check_bit("mid_conv_en", conv_en, 1'b1);
    check_pos("mid_win_col", win_col, 2'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_bit("abort_conv_en", conv_en, 1'b0);
    check_bit("abort_busy", busy, 1'b0);
    check_pos("abort_win_col", win_col, 2'd0);
    check_img("abort_image", image, '0);
    tick();
    load_tile(16'h0020, 1'b0);
    run_frame(16'h0020);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
